// File: rtl/powerup_spawn_ctrl_if.sv
// powerup_spawn_ctrl_if: frame/game/collision inputs and position/visibility/effect outputs of the powerup controller
interface powerup_spawn_ctrl_if;
  logic        startOfFrame;
  logic        gameEnable;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        visible;
  logic        effectActive;
  logic        collectedPulse;
  modport master (
    output startOfFrame, gameEnable, collision,
    input  topLeftX, topLeftY, visible, effectActive, collectedPulse
  );
  modport slave (
    input  startOfFrame, gameEnable, collision,
    output topLeftX, topLeftY, visible, effectActive, collectedPulse
  );
endinterface

// File: rtl/powerup_spawn_ctrl.sv
// powerup_spawn_ctrl: spawn delay, random grid placement, show/blink lifetime, collection and timed effect
module powerup_spawn_ctrl #(
  parameter int SPAWN_DELAY_FRAMES = 300,
  parameter int LIFETIME_FRAMES    = 600,
  parameter int BLINK_FRAMES       = 120,
  parameter int BLINK_PERIOD       = 8,
  parameter int EFFECT_FRAMES      = 300,
  parameter int X_ORIGIN           = 64,
  parameter int Y_ORIGIN           = 64
) (
  input logic                  clk,
  input logic                  resetN,
  powerup_spawn_ctrl_if.slave  bus
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_SPAWN = 3'd1;
  localparam logic [2:0] SHOW       = 3'd2;
  localparam logic [2:0] BLINK      = 3'd3;
  localparam logic [2:0] EFFECT     = 3'd4;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [15:0] bcnt;
  logic        phase;
  logic [15:0] lfsr;
  logic [15:0] lim;
  logic [2:0]  nxt;
  logic        live;
  always_comb begin
    lim  = state == WAIT_SPAWN ? 16'(SPAWN_DELAY_FRAMES - 1) :
           state == SHOW       ? 16'(LIFETIME_FRAMES - BLINK_FRAMES - 1) :
           state == BLINK      ? 16'(BLINK_FRAMES - 1) : 16'(EFFECT_FRAMES - 1);
    nxt  = state == WAIT_SPAWN ? SHOW : state == SHOW ? BLINK : WAIT_SPAWN;
    live = state == SHOW || state == BLINK;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      cnt                <= '0;
      bcnt               <= '0;
      phase              <= 1'b0;
      lfsr               <= 16'hACE1;
      bus.topLeftX       <= 11'(X_ORIGIN);
      bus.topLeftY       <= 11'(Y_ORIGIN);
      bus.visible        <= 1'b0;
      bus.effectActive   <= 1'b0;
      bus.collectedPulse <= 1'b0;
    end else begin
      lfsr               <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      bus.collectedPulse <= 1'b0;
      if (!bus.gameEnable) begin
        state            <= IDLE;
        cnt              <= '0;
        bcnt             <= '0;
        phase            <= 1'b0;
        bus.visible      <= 1'b0;
        bus.effectActive <= 1'b0;
      end else if (state == IDLE) begin
        state <= WAIT_SPAWN;
        cnt   <= '0;
      end else if (live && bus.collision) begin
        state              <= EFFECT;
        cnt                <= '0;
        bus.visible        <= 1'b0;
        bus.effectActive   <= 1'b1;
        bus.collectedPulse <= 1'b1;
      end else if (bus.startOfFrame && cnt != lim) begin
        cnt <= cnt + 16'd1;
        // phase flips after every BLINK_PERIOD-th frame; visible follows its inverse
        if (state == BLINK) begin
          bcnt        <= bcnt == 16'(BLINK_PERIOD - 1) ? '0 : bcnt + 16'd1;
          phase       <= bcnt == 16'(BLINK_PERIOD - 1) ? ~phase : phase;
          bus.visible <= bcnt == 16'(BLINK_PERIOD - 1) ? phase : ~phase;
        end
      end else if (bus.startOfFrame) begin
        state            <= nxt;
        cnt              <= '0;
        bcnt             <= '0;
        phase            <= 1'b0;
        bus.visible      <= state == WAIT_SPAWN || state == SHOW;
        bus.effectActive <= 1'b0;
        if (state == WAIT_SPAWN) begin
          bus.topLeftX <= 11'(X_ORIGIN) + {2'b0, lfsr[3:0], 5'b0};
          bus.topLeftY <= 11'(Y_ORIGIN) + {3'b0, lfsr[6:4], 5'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_powerup_spawn_ctrl.sv
// tb_powerup_spawn_ctrl: randomized and directed stimulus scored against a frame-level reference model
module tb_powerup_spawn_ctrl;
  localparam int SP = 2, LT = 4, BL = 2, BP = 1, EF = 3;
  localparam int M_IDLE = 0, M_WAIT = 1, M_SHOW = 2, M_BLINK = 3, M_EFF = 4;
  typedef struct {
    logic [10:0] x, y;
    logic vis, eff, pul;
  } exp_t;
  logic clk = 0;
  logic resetN;
  int checks = 0, errors = 0, pulses = 0;
  int m_stage = M_IDLE, m_frames = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  exp_t m_out = '{11'd64, 11'd64, 1'b0, 1'b0, 1'b0};
  exp_t q[$];
  powerup_spawn_ctrl_if bus();
  powerup_spawn_ctrl #(
    .SPAWN_DELAY_FRAMES(SP), .LIFETIME_FRAMES(LT), .BLINK_FRAMES(BL),
    .BLINK_PERIOD(BP), .EFFECT_FRAMES(EF), .X_ORIGIN(64), .Y_ORIGIN(64)
  ) dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [10:0] a, input logic [10:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic m_reset();
    m_stage = M_IDLE;
    m_frames = 0;
    m_lfsr = 16'hACE1;
    m_out = '{11'd64, 11'd64, 1'b0, 1'b0, 1'b0};
  endtask
  // Reference: count elapsed frames per stage; blink visibility derived from elapsed frames
  task automatic m_step(input logic ge, input logic sof, input logic col);
    m_out.pul = 1'b0;
    if (!ge) begin
      m_stage = M_IDLE;
      m_frames = 0;
    end else if (m_stage == M_IDLE) begin
      m_stage = M_WAIT;
      m_frames = 0;
    end else if ((m_stage == M_SHOW || m_stage == M_BLINK) && col) begin
      m_stage = M_EFF;
      m_frames = 0;
      m_out.pul = 1'b1;
    end else if (sof) begin
      m_frames++;
      if (m_stage == M_WAIT && m_frames == SP) begin
        m_stage = M_SHOW;
        m_frames = 0;
        m_out.x = 11'(64 + int'(m_lfsr & 16'h000F) * 32);
        m_out.y = 11'(64 + int'((m_lfsr >> 4) & 16'h0007) * 32);
      end else if (m_stage == M_SHOW && m_frames == LT - BL) begin
        m_stage = M_BLINK;
        m_frames = 0;
      end else if ((m_stage == M_BLINK && m_frames == BL) || (m_stage == M_EFF && m_frames == EF)) begin
        m_stage = M_WAIT;
        m_frames = 0;
      end
    end
    m_out.vis = m_stage == M_SHOW || (m_stage == M_BLINK && ((m_frames / BP) % 2 == 0));
    m_out.eff = m_stage == M_EFF;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask
  always @(negedge resetN) begin
    m_reset();
    q.delete();
  end
  always @(posedge clk) begin
    if (!resetN) m_reset();
    else m_step(bus.gameEnable, bus.startOfFrame, bus.collision);
    q.push_back(m_out);
  end
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (bus.collectedPulse === 1'b1) pulses++;
      chk("visible", 11'(bus.visible), 11'(e.vis));
      chk("effectActive", 11'(bus.effectActive), 11'(e.eff));
      chk("collectedPulse", 11'(bus.collectedPulse), 11'(e.pul));
      chk("topLeftX", bus.topLeftX, e.x);
      chk("topLeftY", bus.topLeftY, e.y);
      if (bus.visible === 1'b1) begin
        chk("x_in_grid", 11'(bus.topLeftX >= 64 && bus.topLeftX <= 544 && bus.topLeftX[4:0] == 0), 11'd1);
        chk("y_in_grid", 11'(bus.topLeftY >= 64 && bus.topLeftY <= 288 && bus.topLeftY[4:0] == 0), 11'd1);
      end
    end
  end
  task automatic tick(input logic g, input logic s, input logic c);
    bus.gameEnable = g;
    bus.startOfFrame = s;
    bus.collision = c;
    @(posedge clk);
    #1;
  endtask
  task automatic frame();
    tick(1, 1, 0);
    tick(1, 0, 0);
  endtask
  task automatic wait_stage(input int st, input string n);
    for (int i = 0; i < 200 && m_stage != st; i++) frame();
    checks++;
    if (m_stage != st) begin
      errors++;
      $display("FAIL wait_%s: stage %0d never reached, at %0d", n, st, m_stage);
    end
  endtask
  initial begin
    int p0;
    resetN = 0;
    bus.gameEnable = 0;
    bus.startOfFrame = 0;
    bus.collision = 0;
    repeat (3) tick(0, 0, 0);
    chk("reset_x", bus.topLeftX, 11'd64);
    chk("reset_vis", 11'(bus.visible), 11'd0);
    resetN = 1;
    tick(1, 0, 0);
    // spawn after two frames, visible one clk after the second pulse
    tick(1, 1, 0);
    tick(1, 0, 0);
    chk("vis_after_1_frame", 11'(bus.visible), 11'd0);
    tick(1, 1, 0);
    chk("vis_after_2_frames", 11'(bus.visible), 11'd1);
    // uncollected lifetime: show, blink, respawn
    repeat (10) frame();
    // collision held for 10 clks in SHOW yields one pulse
    wait_stage(M_SHOW, "show");
    p0 = pulses;
    repeat (10) tick(1, 0, 1);
    chk("held_collision_pulses", 11'(pulses - p0), 11'd1);
    chk("effect_high", 11'(bus.effectActive), 11'd1);
    repeat (EF) frame();
    chk("effect_done", 11'(bus.effectActive), 11'd0);
    // collision coincident with expiring frame in BLINK
    wait_stage(M_BLINK, "blink");
    for (int i = 0; i < BL - 1; i++) frame();
    tick(1, 1, 1);
    chk("blink_expire_collide_pulse", 11'(bus.collectedPulse), 11'd1);
    chk("blink_expire_collide_eff", 11'(bus.effectActive), 11'd1);
    tick(1, 0, 0);
    // gameEnable dropped during EFFECT
    tick(0, 0, 0);
    chk("drop_eff", 11'(bus.effectActive), 11'd0);
    chk("drop_vis", 11'(bus.visible), 11'd0);
    tick(1, 0, 0);
    frame();
    chk("reenable_1_frame", 11'(bus.visible), 11'd0);
    tick(1, 1, 0);
    chk("reenable_2_frames", 11'(bus.visible), 11'd1);
    // async reset mid-SHOW
    #2;
    resetN = 0;
    #1;
    chk("async_vis", 11'(bus.visible), 11'd0);
    chk("async_x", bus.topLeftX, 11'd64);
    chk("async_y", bus.topLeftY, 11'd64);
    chk("async_eff", 11'(bus.effectActive), 11'd0);
    repeat (2) tick(0, 0, 0);
    resetN = 1;
    // randomized play
    for (int i = 0; i < 4000; i++)
      tick(($urandom % 150) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
    repeat (3) tick(1, 0, 0);
    chk("saw_pulses", 11'(pulses > 3), 11'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
